// File: rtl/comp_hyst_debounce.sv
// Hysteresis threshold monitor with consecutive-sample debounce.
// Ports: clk, rst_n, en, in_valid, in_data, thr_hi, thr_lo, deb_len -> above, rise, fall, busy.
module gt_cmp #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         gt
);
  assign gt = a > b;
endmodule

module comp_hyst_debounce #(
  parameter int N  = 8,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          in_valid,
  input  logic [N-1:0]  in_data,
  input  logic [N-1:0]  thr_hi,
  input  logic [N-1:0]  thr_lo,
  input  logic [CW-1:0] deb_len,
  output logic          above,
  output logic          rise,
  output logic          fall,
  output logic          busy
);

  // bit1 = above, bit0 = busy
  localparam logic [1:0] LOW       = 2'b00;
  localparam logic [1:0] LOW_PEND  = 2'b01;
  localparam logic [1:0] HIGH      = 2'b10;
  localparam logic [1:0] HIGH_PEND = 2'b11;

  logic [1:0]    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          rise_nx, fall_nx;
  logic          gt_hi, gt_lo;
  logic          hi_s, lo_s;
  logic [CW-1:0] deb_eff;
  logic [CW:0]   cnt_inc;
  logic          done;

  gt_cmp #(.N(N)) u_cmp_hi (
    .a (in_data),
    .b (thr_hi),
    .gt(gt_hi)
  );

  gt_cmp #(.N(N)) u_cmp_lo (
    .a (in_data),
    .b (thr_lo),
    .gt(gt_lo)
  );

  // With crossed thresholds a sample can be both; high wins.
  assign hi_s = gt_hi;
  assign lo_s = !gt_lo && !gt_hi;

  assign deb_eff = (deb_len == '0) ? CW'(1) : deb_len;
  assign cnt_inc = {1'b0, cnt} + 1'b1;
  // >= so a shortened deb_len mid-streak fires at once.
  assign done    = cnt_inc >= {1'b0, deb_eff};

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    rise_nx  = 1'b0;
    fall_nx  = 1'b0;
    if (!en) begin
      state_nx = {state[1], 1'b0};
      cnt_nx   = '0;
    end else if (in_valid) begin
      unique case (state)
        LOW, LOW_PEND: begin
          if (hi_s && done) begin
            state_nx = HIGH;
            cnt_nx   = '0;
            rise_nx  = 1'b1;
          end else if (hi_s) begin
            state_nx = LOW_PEND;
            cnt_nx   = cnt_inc[CW-1:0];
          end else begin
            state_nx = LOW;
            cnt_nx   = '0;
          end
        end
        HIGH, HIGH_PEND: begin
          if (lo_s && done) begin
            state_nx = LOW;
            cnt_nx   = '0;
            fall_nx  = 1'b1;
          end else if (lo_s) begin
            state_nx = HIGH_PEND;
            cnt_nx   = cnt_inc[CW-1:0];
          end else begin
            state_nx = HIGH;
            cnt_nx   = '0;
          end
        end
        default: begin
          state_nx = LOW;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOW;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      rise  <= rise_nx;
      fall  <= fall_nx;
    end
  end

  assign above = state[1];
  assign busy  = state[0];

endmodule

// File: tb/tb_comp_hyst_debounce.sv
// Directed bench for comp_hyst_debounce.
// Checks {above,rise,fall,busy} after each accepted edge.
module tb_comp_hyst_debounce;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       in_valid;
  logic [7:0] in_data;
  logic [7:0] thr_hi;
  logic [7:0] thr_lo;
  logic [3:0] deb_len;
  logic       above, rise, fall, busy;

  int checks = 0;
  int errors = 0;

  comp_hyst_debounce #(.N(8), .CW(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .in_valid(in_valid),
    .in_data (in_data),
    .thr_hi  (thr_hi),
    .thr_lo  (thr_lo),
    .deb_len (deb_len),
    .above   (above),
    .rise    (rise),
    .fall    (fall),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic step(input logic v, input logic [7:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // exp = {above, rise, fall, busy}
  task automatic chk(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {above, rise, fall, busy};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed arfb=%b expected arfb=%b", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    en       = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'd0;
    thr_hi   = 8'd100;
    thr_lo   = 8'd50;
    deb_len  = 4'd3;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset", 4'b0000);
    rst_n = 1'b1;

    // debounced rise
    step(1, 120); chk("rise_s1", 4'b0001);
    step(1, 120); chk("rise_s2", 4'b0001);
    step(1, 120); chk("rise_s3", 4'b1100);
    step(0, 0);   chk("rise_pulse_end", 4'b1000);

    // hysteresis fall
    deb_len = 4'd2;
    step(1, 60);  chk("band_60a", 4'b1000);
    step(1, 60);  chk("band_60b", 4'b1000);
    step(1, 50);  chk("fall_s1_50", 4'b1001);
    step(1, 40);  chk("fall_s2_40", 4'b0010);
    step(0, 0);   chk("fall_pulse_end", 4'b0000);

    // broken streak
    deb_len = 4'd3;
    step(1, 120); chk("brk_s1", 4'b0001);
    step(1, 120); chk("brk_s2", 4'b0001);
    step(1, 75);  chk("brk_band", 4'b0000);
    step(1, 120); chk("brk_restart1", 4'b0001);
    step(1, 120); chk("brk_restart2", 4'b0001);
    step(1, 120); chk("brk_restart3", 4'b1100);

    deb_len = 4'd1;
    step(1, 10);  chk("to_low_a", 4'b0010);

    // idle gaps hold streak
    deb_len = 4'd3;
    step(1, 120); chk("gap_s1", 4'b0001);
    step(0, 120); chk("gap_idle1", 4'b0001);
    step(0, 120); chk("gap_idle2", 4'b0001);
    step(1, 120); chk("gap_s2", 4'b0001);
    step(0, 0);   chk("gap_idle3", 4'b0001);
    step(1, 120); chk("gap_s3", 4'b1100);

    // en=0 mid HIGH_PEND restarts count
    step(1, 10);  chk("en_hp_s1", 4'b1001);
    step(1, 10);  chk("en_hp_s2", 4'b1001);
    en = 1'b0;
    step(1, 10);  chk("en_off_hp", 4'b1000);
    en = 1'b1;
    step(1, 10);  chk("en_hp_r1", 4'b1001);
    step(1, 10);  chk("en_hp_r2", 4'b1001);
    step(1, 10);  chk("en_hp_r3", 4'b0010);

    // en=0 mid LOW_PEND
    step(1, 120); chk("en_lp_s1", 4'b0001);
    en = 1'b0;
    step(1, 120); chk("en_off_lp", 4'b0000);
    en = 1'b1;
    step(1, 120); chk("en_lp_r1", 4'b0001);

    // deb_len shrunk mid-streak fires on next sample
    step(1, 120); chk("shrink_s2", 4'b0001);
    deb_len = 4'd1;
    step(1, 120); chk("shrink_fire", 4'b1100);
    step(1, 10);  chk("to_low_b", 4'b0010);

    // deb_len=0 acts as 1
    deb_len = 4'd0;
    step(1, 200); chk("deb0_rise", 4'b1100);
    step(1, 10);  chk("deb0_fall", 4'b0010);

    // threshold equality
    deb_len = 4'd1;
    step(1, 100); chk("eq_hi_not_hi", 4'b0000);
    step(1, 101); chk("hi_plus1", 4'b1100);
    step(1, 51);  chk("lo_plus1", 4'b1000);
    step(1, 50);  chk("eq_lo_is_lo", 4'b0010);

    // crossed thresholds: high wins
    thr_lo = 8'd200;
    thr_hi = 8'd100;
    step(1, 150); chk("cross_rise", 4'b1100);
    step(1, 150); chk("cross_hold", 4'b1000);
    step(1, 90);  chk("cross_fall", 4'b0010);
    thr_lo = 8'd50;

    // async reset mid HIGH_PEND
    step(1, 120); chk("pre_rst_high", 4'b1100);
    deb_len = 4'd3;
    step(1, 10);  chk("pre_rst_hp", 4'b1001);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", 4'b0000);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    deb_len = 4'd1;
    @(posedge clk);
    #1;
    chk("post_rst_idle", 4'b0000);
    step(1, 120); chk("post_rst_rise", 4'b1100);
    step(0, 0);   chk("post_rst_end", 4'b1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
